// File: rtl/drink_sequencer_if.sv
// ---------------------------------------------------------------------------
// drink_sequencer_if
//   Signal bundle between the user-panel logic (master) and the recipe
//   controller drink_sequencer (slave).
//
//   Panel -> controller : start, bebida[1:0], azucar[1:0], cup_present, cancel
//   Controller -> panel : en_cafe, en_leche, en_chocolate, en_azucar,
//                         busy, done, err
// ---------------------------------------------------------------------------
interface drink_sequencer_if;
    logic       start;
    logic [1:0] bebida;
    logic [1:0] azucar;
    logic       cup_present;
    logic       cancel;
    logic       en_cafe;
    logic       en_leche;
    logic       en_chocolate;
    logic       en_azucar;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, bebida, azucar, cup_present, cancel,
        input  en_cafe, en_leche, en_chocolate, en_azucar, busy, done, err
    );

    modport slave (
        input  start, bebida, azucar, cup_present, cancel,
        output en_cafe, en_leche, en_chocolate, en_azucar, busy, done, err
    );
endinterface

// File: rtl/drink_sequencer.sv
// ---------------------------------------------------------------------------
// drink_sequencer
//   Recipe controller for the beverage machine. Accepts a drink and sugar
//   selection, then drives the coffee, milk, chocolate and sugar dispenser
//   enables one at a time, in that order, for the recipe's unit counts.
//   Cup removal aborts into ERROR; cancel aborts back to IDLE.
//
// Parameters
//   UNIT_CYCLES  clock cycles one dispensed unit keeps its enable high (>=1)
//
// Ports
//   clk   in  clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   drink_sequencer_if.slave
//         in : start, bebida, azucar, cup_present, cancel
//         out: en_cafe, en_leche, en_chocolate, en_azucar, busy, done, err
// ---------------------------------------------------------------------------
module drink_sequencer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    drink_sequencer_if.slave  bus
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    // Encoding order matters: the dispensing stages are numbered in the
    // order they run, which next_stage() relies on.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAFE   = 3'd1,
        S_LECHE  = 3'd2,
        S_CHOC   = 3'd3,
        S_AZUCAR = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [1:0]     sel_bebida;
    logic [1:0]     sel_azucar;
    logic [CW-1:0]  cyc_cnt;
    logic [1:0]     unit_cnt;
    logic           accept;
    logic [5:0]     rec_lat;
    logic [5:0]     rec_in;
    logic [1:0]     units_cur;
    logic           last_cycle;
    logic           last_unit;

    // Unit counts {cafe, leche, chocolate} for each drink code.
    function automatic logic [5:0] recipe(input logic [1:0] b);
        logic [5:0] r;
        case (b)
            2'b00:   r = {2'd3, 2'd0, 2'd0};
            2'b01:   r = {2'd2, 2'd2, 2'd0};
            2'b10:   r = {2'd2, 2'd1, 2'd2};
            default: r = {2'd0, 2'd2, 2'd3};
        endcase
        return r;
    endfunction

    // First stage strictly after 'from' with a nonzero unit count, or DONE.
    // Skipping happens inside one transition, so no idle gap cycles appear.
    function automatic state_t next_stage(input state_t     from,
                                          input logic [5:0] rec,
                                          input logic [1:0] sugar);
        state_t r;
        if (from < S_CAFE && rec[5:4] != 2'd0)
            r = S_CAFE;
        else if (from < S_LECHE && rec[3:2] != 2'd0)
            r = S_LECHE;
        else if (from < S_CHOC && rec[1:0] != 2'd0)
            r = S_CHOC;
        else if (from < S_AZUCAR && sugar != 2'd0)
            r = S_AZUCAR;
        else
            r = S_DONE;
        return r;
    endfunction

    assign rec_lat = recipe(sel_bebida);
    assign rec_in  = recipe(bus.bebida);

    always_comb begin
        units_cur = 2'd0;
        case (state)
            S_CAFE:   units_cur = rec_lat[5:4];
            S_LECHE:  units_cur = rec_lat[3:2];
            S_CHOC:   units_cur = rec_lat[1:0];
            S_AZUCAR: units_cur = sel_azucar;
            default:  units_cur = 2'd0;
        endcase
    end

    assign last_cycle = (cyc_cnt == CW'(UNIT_CYCLES - 1));
    assign last_unit  = (unit_cnt == units_cur - 2'd1);

    // Next-state logic
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && bus.cup_present) begin
                    accept  = 1'b1;
                    state_n = next_stage(S_IDLE, rec_in, bus.azucar);
                end
            end
            S_CAFE, S_LECHE, S_CHOC, S_AZUCAR: begin
                // Cup removal outranks cancel.
                if (!bus.cup_present)
                    state_n = S_ERROR;
                else if (bus.cancel)
                    state_n = S_IDLE;
                else if (last_cycle && last_unit)
                    state_n = next_stage(state, rec_lat, sel_azucar);
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERROR: begin
                // A start still held from before the fault blocks the exit,
                // so the user must release it before a new drink is taken.
                if (bus.cup_present && !bus.start)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register and latched selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sel_bebida <= 2'd0;
            sel_azucar <= 2'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                sel_bebida <= bus.bebida;
                sel_azucar <= bus.azucar;
            end
        end
    end

    // Cycle/unit counters: cleared on every state change, so each stage
    // starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            unit_cnt <= 2'd0;
        end else if (state_n != state) begin
            cyc_cnt  <= '0;
            unit_cnt <= 2'd0;
        end else if (state inside {S_CAFE, S_LECHE, S_CHOC, S_AZUCAR}) begin
            if (last_cycle) begin
                cyc_cnt  <= '0;
                unit_cnt <= unit_cnt + 2'd1;
            end else begin
                cyc_cnt  <= cyc_cnt + CW'(1);
            end
        end
    end

    // Moore outputs decoded from state; reset forces IDLE asynchronously,
    // so every enable drops as soon as rst rises.
    assign bus.en_cafe      = (state == S_CAFE);
    assign bus.en_leche     = (state == S_LECHE);
    assign bus.en_chocolate = (state == S_CHOC);
    assign bus.en_azucar    = (state == S_AZUCAR);
    assign bus.done         = (state == S_DONE);
    assign bus.err          = (state == S_ERROR);
    assign bus.busy         = (state != S_IDLE) && (state != S_ERROR);

endmodule
